rsv_station: RTL and testbench
==============================

# rsv_station

Reservation station sitting between the decoder and one execution unit. It accepts dispatched micro-ops on the decoder-to-reservation-station handshake and holds up to DEPTH entries. It snoops the common data bus so pending source operands can capture their values. It issues the oldest fully-ready entry to the execution unit over the reservation-station-to-execution-unit handshake.

## Interface
Parameters:
- TAG_W, 4, width of ROB/CDB tags
- OPC_W, 4, width of unit opcode
- DEPTH, 4, number of entries (power of 2, ≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- dec_req  in  1  dispatch request
- dec_rdy  out  1  at least one free entry
- dec_tag  in  TAG_W  destination tag of dispatched op
- dec_opc  in  OPC_W  opcode
- dec_src1_vld, dec_src2_vld  in  1 each  source value already valid
- dec_src1_tag, dec_src2_tag  in  TAG_W each  producer tag when not valid
- dec_src1_wdata, dec_src2_wdata  in  32 each  source value when valid
- dec_offset  in  12  immediate/offset
- exu_req  out  1  issue request
- exu_rdy  in  1  unit accepts
- exu_tag  out  TAG_W  destination tag of issued op
- exu_opc  out  OPC_W  opcode of issued op
- exu_src1, exu_src2  out  32 each  operand values
- exu_offset  out  12  offset of issued op
- cdb_wr  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  broadcast tag
- cdb_wdata  in  32  broadcast value

## Operation
- Entry state: vld, tag, opc, offset, s1_vld/s1_tag/s1_data, s2_vld/s2_tag/s2_data, age (clog2(DEPTH) bits).
- Dispatch: occurs when dec_req && dec_rdy. The op is written into the lowest-index free entry.
- Dispatch bypass: if a source is not valid and cdb_wr && cdb_tag == that source tag in the same cycle, the entry stores cdb_wdata with that source marked valid.
- Snoop: every valid entry with an invalid source whose tag equals cdb_tag while cdb_wr=1 captures cdb_wdata and sets that source valid. Src1 and src2 are handled independently, so both may capture in one cycle.
- Age: a new entry starts at age 0. On each dispatch, every other valid entry's age increments, saturating at DEPTH-1. Larger age means older.
- Ready: an entry is ready when vld && s1_vld && s2_vld.
- Selection: oldest ready entry; ties go to the lowest index.
- exu_req = 1 whenever any entry is ready or a lock is held. The exu_* fields come combinationally from the selected entry.
- Lock: if exu_req && !exu_rdy, the selected index is registered and locked. The outputs hold that entry, stable, until exu_rdy. Entries that become older-and-ready meanwhile do not preempt it.
- Issue: on exu_req && exu_rdy, the selected entry's vld clears and the lock releases.
- dec_rdy = OR of !vld over entries, computed from current state only. An entry freed by issue becomes allocatable the next cycle. A full station issuing this cycle still drives dec_rdy=0.

## Timing
- Reset (rst_n=0 at edge) clears all vld, ages, and the lock. The cycle after, dec_rdy=1 and exu_req=0; exu_* data values are don't-care while exu_req=0.
- Dispatch-to-issue latency:
  - Op dispatched with both sources valid in cycle N: exu_req can assert in cycle N+1 at the earliest.
  - Source captured from the CDB in cycle N: the entry is eligible in cycle N+1. There is no CDB-to-exu bypass.
- Issue and dispatch in the same cycle are both performed. The dispatch never targets the entry being issued.
- CDB broadcast in the issue cycle: it does not alter the entry being issued, because that entry is already ready.
- Full, DEPTH valid entries: dec_rdy=0. A dec_req is ignored and no state changes.
- Empty with no lock: exu_req=0.
- exu_rdy while exu_req=0 has no effect.
- Reset mid-operation discards all entries and any held lock in that cycle.

## Test plan
- Reset, then dispatch tag=3, opc=2, src1=0x11 valid, src2=0x22 valid, offset=0x7FF in cycle 0, with exu_rdy=1 → cycle 1: exu_req=1, exu_tag=3, exu_src1=0x11, exu_src2=0x22, exu_offset=0x7FF. Cycle 2: exu_req=0.
- Dispatch with src1 waiting on tag 5, then cdb_wr with tag=5, data=0xDEADBEEF, two cycles later → exu_req asserts exactly one cycle after the broadcast, with exu_src1=0xDEADBEEF.
- Dispatch with src2 waiting on tag 6 while cdb_wr, tag=6, data=0x1234 in the same cycle → the op issues the next cycle with exu_src2=0x1234.
- Fill 4 entries with exu_rdy=0 → dec_rdy=0 and further dec_req is ignored. Raise exu_rdy for one cycle → dec_rdy=1 the following cycle.
- Hold exu_rdy=0 while the younger entry B is selected. Make the older entry A ready via the CDB → outputs stay on B until exu_rdy=1. A issues in the next cycle.
- Dispatch A then B, both ready, with exu_rdy=1 → A issues before B. Assert rst_n=0 while B is pending → exu_req=0 and dec_rdy=1 the next cycle.

Source files
------------

// File: rtl/rsv_station.sv
// rsv_station: reservation station in front of one execution unit.
// Holds DEPTH micro-ops, snoops the CDB, issues the oldest ready entry.
module rsv_station #(
  parameter int TAG_W = 4,
  parameter int OPC_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dec_req,
  output logic             dec_rdy,
  input  logic [TAG_W-1:0] dec_tag,
  input  logic [OPC_W-1:0] dec_opc,
  input  logic             dec_src1_vld,
  input  logic             dec_src2_vld,
  input  logic [TAG_W-1:0] dec_src1_tag,
  input  logic [TAG_W-1:0] dec_src2_tag,
  input  logic [31:0]      dec_src1_wdata,
  input  logic [31:0]      dec_src2_wdata,
  input  logic [11:0]      dec_offset,
  output logic             exu_req,
  input  logic             exu_rdy,
  output logic [TAG_W-1:0] exu_tag,
  output logic [OPC_W-1:0] exu_opc,
  output logic [31:0]      exu_src1,
  output logic [31:0]      exu_src2,
  output logic [11:0]      exu_offset,
  input  logic             cdb_wr,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_wdata
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(DEPTH - 1);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [OPC_W-1:0] opc;
    logic [11:0]      offset;
    logic             s1_vld;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      s1_data;
    logic             s2_vld;
    logic [TAG_W-1:0] s2_tag;
    logic [31:0]      s2_data;
    logic [IDX_W-1:0] age;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             new_ent;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;

  logic             any_rdy;
  logic [IDX_W-1:0] old_idx;
  logic [IDX_W-1:0] best_age;
  logic [IDX_W-1:0] sel_idx;
  logic             has_free;
  logic [IDX_W-1:0] free_idx;
  logic             dispatch;
  logic             issue;

  // Oldest ready entry; strict compare keeps the lowest index on ties.
  always_comb begin
    any_rdy  = 1'b0;
    old_idx  = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].vld && ent_q[i].s1_vld && ent_q[i].s2_vld &&
          (!any_rdy || ent_q[i].age > best_age)) begin
        any_rdy  = 1'b1;
        old_idx  = IDX_W'(i);
        best_age = ent_q[i].age;
      end
    end
  end

  always_comb begin
    has_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].vld) begin
        has_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign sel_idx    = lock_q ? lock_idx_q : old_idx;
  assign exu_req    = lock_q | any_rdy;
  assign exu_tag    = ent_q[sel_idx].tag;
  assign exu_opc    = ent_q[sel_idx].opc;
  assign exu_src1   = ent_q[sel_idx].s1_data;
  assign exu_src2   = ent_q[sel_idx].s2_data;
  assign exu_offset = ent_q[sel_idx].offset;

  assign dec_rdy  = has_free;
  assign dispatch = dec_req & has_free;
  assign issue    = exu_req & exu_rdy;

  // Incoming op, with a same-cycle CDB hit folded in.
  always_comb begin
    new_ent         = '0;
    new_ent.vld     = 1'b1;
    new_ent.tag     = dec_tag;
    new_ent.opc     = dec_opc;
    new_ent.offset  = dec_offset;
    new_ent.s1_tag  = dec_src1_tag;
    new_ent.s2_tag  = dec_src2_tag;
    new_ent.s1_vld  = dec_src1_vld |
                      (cdb_wr && cdb_tag == dec_src1_tag);
    new_ent.s2_vld  = dec_src2_vld |
                      (cdb_wr && cdb_tag == dec_src2_tag);
    new_ent.s1_data = dec_src1_vld ? dec_src1_wdata : cdb_wdata;
    new_ent.s2_data = dec_src2_vld ? dec_src2_wdata : cdb_wdata;
    new_ent.age     = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i].vld <= 1'b0;
        ent_q[i].age <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].vld && cdb_wr) begin
          if (!ent_q[i].s1_vld && cdb_tag == ent_q[i].s1_tag) begin
            ent_q[i].s1_vld  <= 1'b1;
            ent_q[i].s1_data <= cdb_wdata;
          end
          if (!ent_q[i].s2_vld && cdb_tag == ent_q[i].s2_tag) begin
            ent_q[i].s2_vld  <= 1'b1;
            ent_q[i].s2_data <= cdb_wdata;
          end
        end
        if (dispatch && ent_q[i].vld && ent_q[i].age != AGE_MAX) begin
          ent_q[i].age <= ent_q[i].age + IDX_W'(1);
        end
      end
      if (issue) begin
        ent_q[sel_idx].vld <= 1'b0;
      end
      if (dispatch) begin
        ent_q[free_idx] <= new_ent;
      end
      if (issue) begin
        lock_q <= 1'b0;
      end else if (exu_req) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_rsv_station.sv
// Testbench for rsv_station: directed vectors, literal expectations,
// and a per-cycle comparison against an entry-level behavioural model.
module tb_rsv_station;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_req = 1'b0;
  logic        dec_rdy;
  logic [3:0]  dec_tag = '0;
  logic [3:0]  dec_opc = '0;
  logic        dec_src1_vld = 1'b0;
  logic        dec_src2_vld = 1'b0;
  logic [3:0]  dec_src1_tag = '0;
  logic [3:0]  dec_src2_tag = '0;
  logic [31:0] dec_src1_wdata = '0;
  logic [31:0] dec_src2_wdata = '0;
  logic [11:0] dec_offset = '0;
  logic        exu_req;
  logic        exu_rdy = 1'b0;
  logic [3:0]  exu_tag;
  logic [3:0]  exu_opc;
  logic [31:0] exu_src1;
  logic [31:0] exu_src2;
  logic [11:0] exu_offset;
  logic        cdb_wr = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_wdata = '0;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  rsv_station #(.TAG_W(4), .OPC_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_req(dec_req), .dec_rdy(dec_rdy),
    .dec_tag(dec_tag), .dec_opc(dec_opc),
    .dec_src1_vld(dec_src1_vld), .dec_src2_vld(dec_src2_vld),
    .dec_src1_tag(dec_src1_tag), .dec_src2_tag(dec_src2_tag),
    .dec_src1_wdata(dec_src1_wdata), .dec_src2_wdata(dec_src2_wdata),
    .dec_offset(dec_offset),
    .exu_req(exu_req), .exu_rdy(exu_rdy),
    .exu_tag(exu_tag), .exu_opc(exu_opc),
    .exu_src1(exu_src1), .exu_src2(exu_src2),
    .exu_offset(exu_offset),
    .cdb_wr(cdb_wr), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Model: one record per slot, age as an integer, lock as a slot number.
  bit          m_vld [DEPTH];
  logic [3:0]  m_tag [DEPTH];
  logic [3:0]  m_opc [DEPTH];
  logic [11:0] m_off [DEPTH];
  bit          m_s1v [DEPTH];
  bit          m_s2v [DEPTH];
  logic [3:0]  m_s1t [DEPTH];
  logic [3:0]  m_s2t [DEPTH];
  logic [31:0] m_s1d [DEPTH];
  logic [31:0] m_s2d [DEPTH];
  int          m_age [DEPTH];
  int          m_lock = -1;

  function automatic int m_sel();
    int best;
    if (m_lock >= 0) return m_lock;
    best = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_vld[i] && m_s1v[i] && m_s2v[i])
        if (best < 0 || m_age[i] > m_age[best]) best = i;
    return best;
  endfunction

  function automatic bit m_free();
    for (int i = 0; i < DEPTH; i++) if (!m_vld[i]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int sel;
    int fr;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_vld[i] = 1'b0;
        m_age[i] = 0;
      end
      m_lock = -1;
    end else begin
      sel = m_sel();
      fr = -1;
      for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) fr = i;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_vld[i] && cdb_wr && !m_s1v[i] && m_s1t[i] == cdb_tag) begin
          m_s1v[i] = 1'b1;
          m_s1d[i] = cdb_wdata;
        end
        if (m_vld[i] && cdb_wr && !m_s2v[i] && m_s2t[i] == cdb_tag) begin
          m_s2v[i] = 1'b1;
          m_s2d[i] = cdb_wdata;
        end
      end
      if (sel >= 0) begin
        if (exu_rdy) begin
          m_vld[sel] = 1'b0;
          m_lock = -1;
        end else m_lock = sel;
      end
      if (dec_req && fr >= 0) begin
        for (int i = 0; i < DEPTH; i++)
          if (m_vld[i] && m_age[i] < DEPTH - 1) m_age[i]++;
        m_vld[fr] = 1'b1;
        m_tag[fr] = dec_tag;
        m_opc[fr] = dec_opc;
        m_off[fr] = dec_offset;
        m_age[fr] = 0;
        m_s1t[fr] = dec_src1_tag;
        m_s2t[fr] = dec_src2_tag;
        m_s1v[fr] = dec_src1_vld || (cdb_wr && cdb_tag == dec_src1_tag);
        m_s2v[fr] = dec_src2_vld || (cdb_wr && cdb_tag == dec_src2_tag);
        m_s1d[fr] = dec_src1_vld ? dec_src1_wdata : cdb_wdata;
        m_s2d[fr] = dec_src2_vld ? dec_src2_wdata : cdb_wdata;
      end
    end
  end

  always @(negedge clk) begin : compare
    int s;
    if (chk_en) begin
      s = m_sel();
      chk("cyc_dec_rdy", 128'(dec_rdy), 128'(m_free()));
      chk("cyc_exu_req", 128'(exu_req), 128'(s >= 0));
      if (s >= 0)
        chk("cyc_payload",
            128'({exu_tag, exu_opc, exu_src1, exu_src2, exu_offset}),
            128'({m_tag[s], m_opc[s], m_s1d[s], m_s2d[s], m_off[s]}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    dec_req = 1'b0;
    cdb_wr  = 1'b0;
  endtask

  task automatic disp(input logic [3:0] t, input logic [3:0] o,
                      input bit v1, input logic [3:0] t1,
                      input logic [31:0] d1,
                      input bit v2, input logic [3:0] t2,
                      input logic [31:0] d2,
                      input logic [11:0] off);
    dec_req        = 1'b1;
    dec_tag        = t;
    dec_opc        = o;
    dec_src1_vld   = v1;
    dec_src1_tag   = t1;
    dec_src1_wdata = d1;
    dec_src2_vld   = v2;
    dec_src2_tag   = t2;
    dec_src2_wdata = d2;
    dec_offset     = off;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] d);
    cdb_wr    = 1'b1;
    cdb_tag   = t;
    cdb_wdata = d;
  endtask

  initial begin
    // Reset
    step();
    step();
    chk_en = 1'b1;
    rst_n = 1'b1;
    chk("rst_dec_rdy", 128'(dec_rdy), 128'(1));
    chk("rst_exu_req", 128'(exu_req), 128'(0));

    // Both sources valid: issue one cycle later
    exu_rdy = 1'b1;
    disp(4'd3, 4'd2, 1, 4'd0, 32'h11, 1, 4'd0, 32'h22, 12'h7FF);
    step();
    chk("t1_req", 128'(exu_req), 128'(1));
    chk("t1_fields", 128'({exu_tag, exu_opc, exu_src1, exu_src2, exu_offset}),
        128'({4'd3, 4'd2, 32'h11, 32'h22, 12'h7FF}));
    step();
    chk("t1_drained", 128'(exu_req), 128'(0));

    // Src1 waits on tag 5; broadcast two cycles later
    disp(4'd7, 4'd1, 0, 4'd5, 32'h0, 1, 4'd0, 32'h2, 12'h010);
    step();
    chk("t2_wait_a", 128'(exu_req), 128'(0));
    step();
    chk("t2_wait_b", 128'(exu_req), 128'(0));
    bcast(4'd5, 32'hDEADBEEF);
    step();
    chk("t2_req", 128'(exu_req), 128'(1));
    chk("t2_src1", 128'(exu_src1), 128'(32'hDEADBEEF));
    chk("t2_tag", 128'(exu_tag), 128'(7));
    step();
    chk("t2_drained", 128'(exu_req), 128'(0));

    // Dispatch-cycle CDB bypass on src2
    disp(4'd8, 4'd3, 1, 4'd0, 32'h5, 0, 4'd6, 32'h0, 12'h020);
    bcast(4'd6, 32'h1234);
    step();
    chk("t3_req", 128'(exu_req), 128'(1));
    chk("t3_src2", 128'(exu_src2), 128'(32'h1234));
    step();

    // Fill with exu_rdy low, full station ignores dispatch
    exu_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      disp(4'(i), 4'd4, 1, 4'd0, 32'(i), 1, 4'd0, 32'(2 * i), 12'(i));
      step();
    end
    chk("t4_full", 128'(dec_rdy), 128'(0));
    chk("t4_head", 128'(exu_tag), 128'(1));
    disp(4'd9, 4'd9, 1, 4'd0, 32'h99, 1, 4'd0, 32'h99, 12'h099);
    step();
    chk("t4_ignored_rdy", 128'(dec_rdy), 128'(0));
    chk("t4_ignored_head", 128'(exu_tag), 128'(1));
    exu_rdy = 1'b1;
    step();
    exu_rdy = 1'b0;
    chk("t4_freed", 128'(dec_rdy), 128'(1));
    chk("t4_next", 128'(exu_tag), 128'(2));
    exu_rdy = 1'b1;
    step();
    step();
    step();
    chk("t4_empty", 128'(exu_req), 128'(0));

    // Lock: younger B held while older A becomes ready
    exu_rdy = 1'b0;
    disp(4'd10, 4'd5, 0, 4'd12, 32'h0, 1, 4'd0, 32'hA2, 12'h0A0);
    step();
    disp(4'd11, 4'd6, 1, 4'd0, 32'hB1, 1, 4'd0, 32'hB2, 12'h0B0);
    step();
    chk("t5_b_sel", 128'(exu_tag), 128'(11));
    bcast(4'd12, 32'hAAAA5555);
    step();
    chk("t5_locked_a", 128'(exu_tag), 128'(11));
    step();
    chk("t5_locked_b", 128'(exu_src1), 128'(32'hB1));
    exu_rdy = 1'b1;
    step();
    chk("t5_a_tag", 128'(exu_tag), 128'(10));
    chk("t5_a_src1", 128'(exu_src1), 128'(32'hAAAA5555));
    step();
    chk("t5_empty", 128'(exu_req), 128'(0));

    // Program order issue, then reset with B pending
    disp(4'd13, 4'd7, 1, 4'd0, 32'hC1, 1, 4'd0, 32'hC2, 12'h0C0);
    step();
    chk("t6_a_first", 128'(exu_tag), 128'(13));
    disp(4'd14, 4'd8, 1, 4'd0, 32'hD1, 1, 4'd0, 32'hD2, 12'h0D0);
    step();
    chk("t6_b_second", 128'(exu_tag), 128'(14));
    exu_rdy = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_req", 128'(exu_req), 128'(0));
    chk("t6_rst_rdy", 128'(dec_rdy), 128'(1));

    // Saturated ages tie: lower slot wins although younger
    exu_rdy = 1'b1;
    disp(4'd1, 4'd1, 1, 4'd0, 32'h1, 1, 4'd0, 32'h1, 12'h001);
    step();
    disp(4'd2, 4'd2, 0, 4'd7, 32'h0, 1, 4'd0, 32'h2, 12'h002);
    step();
    disp(4'd3, 4'd3, 0, 4'd7, 32'h0, 0, 4'd7, 32'h0, 12'h003);
    step();
    disp(4'd4, 4'd4, 0, 4'd8, 32'h0, 1, 4'd0, 32'h4, 12'h004);
    step();
    disp(4'd5, 4'd5, 0, 4'd9, 32'h0, 1, 4'd0, 32'h5, 12'h005);
    step();
    bcast(4'd8, 32'h88);
    step();
    chk("t7_s_sel", 128'(exu_tag), 128'(4));
    step();
    disp(4'd6, 4'd6, 0, 4'd9, 32'h0, 0, 4'd9, 32'h0, 12'h006);
    step();
    bcast(4'd7, 32'h77);
    step();
    chk("t7_tie_low", 128'(exu_tag), 128'(3));
    chk("t7_both_src", 128'({exu_src1, exu_src2}), 128'({32'h77, 32'h77}));
    step();
    chk("t7_tie_next", 128'(exu_tag), 128'(2));
    step();
    chk("t7_gap", 128'(exu_req), 128'(0));
    bcast(4'd9, 32'h99);
    step();
    chk("t7_older_t", 128'(exu_tag), 128'(5));
    step();
    chk("t7_last_u", 128'(exu_tag), 128'(6));
    step();
    step();
    chk("t7_empty", 128'(exu_req), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
